ifetch_stage: RTL and testbench
===============================

IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 Parameter IMEM_DEPTH, default 128: instruction-memory depth in 32-bit words; power of two; index width AW = log2(IMEM_DEPTH).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 EX_MEM_pcsrc  input  1  taken-branch redirect from EX/MEM.
REQ-005 EX_MEM_npc  input  32  redirect target, word address.
REQ-006 stall  input  1  hold PC and IF/ID latch (hazard unit).
REQ-007 flush  input  1  squash IF/ID contents to NOP.
REQ-008 imem_we  input  1  instruction-memory load strobe.
REQ-009 imem_waddr  input  AW  load word index.
REQ-010 imem_wdata  input  32  load data.
REQ-011 pc_out  output  32  current PC, word address.
REQ-012 IF_ID_instrout  output  32  latched instruction, to decode.
REQ-013 IF_ID_npcout  output  32  latched PC+1, to decode.
REQ-014 IF_ID_valid  output  1  latched instruction is real, not a bubble.

Function
REQ-015 PC counts words; sequential next PC = PC + 1, modulo 2^32 (0xFFFFFFFF -> 0x00000000).
REQ-016 Memory index = PC[AW-1:0]; upper PC bits ignored, so the fetch address wraps every IMEM_DEPTH words.
REQ-017 Memory read: combinational from the array; the IF/ID latch registers it, giving 1-cycle fetch latency.
REQ-018 Memory write: on a clock edge with imem_we=1, mem[imem_waddr] <= imem_wdata.
REQ-019 A write and a fetch to the same index in the same cycle: IF/ID captures the old word (read-before-write).
REQ-020 PC update priority, highest first:
- rst: PC <= 0.
- EX_MEM_pcsrc: PC <= EX_MEM_npc; this applies even when stall=1.
- stall: PC holds.
- otherwise: PC <= PC + 1.
REQ-021 IF/ID update priority, highest first:
- rst: instr=0, npc=0, valid=0.
- flush or EX_MEM_pcsrc: instr=0 (NOP), npc=0, valid=0.
- stall: all IF/ID fields hold.
- otherwise: instr <= mem[PC idx], npc <= PC + 1, valid <= 1.
REQ-022 pc_out is the PC register, driven directly with no added delay.
REQ-023 Bubbles are all-zero words (sll $0,$0,0); the decode stage needs no special handling for them.
REQ-024 stall and flush asserted together: flush wins for IF/ID; PC holds unless EX_MEM_pcsrc=1.
REQ-025 The block holds no other state; the outputs depend only on the PC, the IF/ID latch and the memory array.

Reset
REQ-026 With rst=1 at a clock edge, all outputs are 0 after that edge: pc_out, IF_ID_instrout, IF_ID_npcout, IF_ID_valid.
REQ-027 Reset does not clear instruction memory; contents loaded before reset are preserved.
REQ-028 Reset mid-stall or mid-redirect takes priority; on the first cycle after rst deasserts, mem[0] is fetched.
REQ-029 imem_we is honoured during reset, so the program can be loaded while the core is held in reset.

Verification
REQ-030 Sequential fetch:
- Stimulus: load mem[0..3] = 0xA,0xB,0xC,0xD under reset, then release rst.
- Response: pc_out runs 0,1,2,3; one cycle later IF_ID_instrout runs 0xA,0xB,0xC and IF_ID_npcout runs 1,2,3, with valid=1.
REQ-031 Stall:
- Stimulus: assert stall for 2 cycles while PC=2.
- Response: pc_out stays 2 and IF_ID holds (instr 0xB, npc 2) for both cycles; after release the sequence resumes with 0xC, npc 3.
REQ-032 Redirect:
- Stimulus: EX_MEM_pcsrc=1, EX_MEM_npc=0x40 for one cycle.
- Response: next pc_out=0x40; IF_ID instr=0, npc=0, valid=0; one cycle later IF_ID instr=mem[0x40 mod 128], npc=0x41.
REQ-033 Redirect during stall:
- Stimulus: stall=1 and pcsrc=1 (target 5) in the same cycle.
- Response: pc_out=5; IF_ID shows a bubble (valid=0).
REQ-034 Wrap-around:
- Stimulus: redirect to 0xFFFFFFFF.
- Response: fetch uses mem[127]; IF_ID_npcout=0x00000000; next pc_out=0.
REQ-035 Write/read collision:
- Stimulus: mem[3]=0x11 and PC=3; write 0x22 to index 3 in the same cycle.
- Response: IF_ID_instrout=0x11; after redirecting back to 3, IF_ID_instrout=0x22.

Source files
------------

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: word-addressed PC, on-chip instruction memory with a load port,
// and the IF/ID pipeline latch feeding decode.
module ifetch_stage #(
    parameter int  IMEM_DEPTH = 128,
    localparam int AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          EX_MEM_pcsrc,
    input  logic [31:0]   EX_MEM_npc,
    input  logic          stall,
    input  logic          flush,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_waddr,
    input  logic [31:0]   imem_wdata,
    output logic [31:0]   pc_out,
    output logic [31:0]   IF_ID_instrout,
    output logic [31:0]   IF_ID_npcout,
    output logic          IF_ID_valid
);

    logic [31:0]   mem_q [IMEM_DEPTH];

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   npc_q, npc_d;
    logic          valid_q, valid_d;

    logic [AW-1:0] fetch_idx;
    logic [31:0]   fetch_word;
    logic [31:0]   pc_inc;

    // Upper PC bits are ignored, so fetch wraps every IMEM_DEPTH words.
    assign fetch_idx  = pc_q[AW-1:0];
    assign fetch_word = mem_q[fetch_idx];
    assign pc_inc     = pc_q + 32'd1;

    always_comb begin
        pc_d = pc_q;
        if (EX_MEM_pcsrc) begin
            pc_d = EX_MEM_npc;
        end else if (!stall) begin
            pc_d = pc_inc;
        end
    end

    // A redirect squashes the wrong-path instruction just like an explicit flush.
    always_comb begin
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        if (flush || EX_MEM_pcsrc) begin
            instr_d = 32'd0;
            npc_d   = 32'd0;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = fetch_word;
            npc_d   = pc_inc;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= 32'd0;
            instr_q <= 32'd0;
            npc_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    // Memory is loadable during reset and never cleared by it; the fetch above sees the old word.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem_q[imem_waddr] <= imem_wdata;
        end
    end

    assign pc_out         = pc_q;
    assign IF_ID_instrout = instr_q;
    assign IF_ID_npcout   = npc_q;
    assign IF_ID_valid    = valid_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: expected post-edge state is queued when each step is driven
// and popped for comparison one time unit after the clock edge.
module tb_ifetch_stage;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          EX_MEM_pcsrc;
    logic [31:0]   EX_MEM_npc;
    logic          stall;
    logic          flush;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [31:0]   pc_out;
    logic [31:0]   IF_ID_instrout;
    logic [31:0]   IF_ID_npcout;
    logic          IF_ID_valid;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ifetch_stage #(.IMEM_DEPTH(128)) dut (
        .clk            (clk),
        .rst            (rst),
        .EX_MEM_pcsrc   (EX_MEM_pcsrc),
        .EX_MEM_npc     (EX_MEM_npc),
        .stall          (stall),
        .flush          (flush),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .pc_out         (pc_out),
        .IF_ID_instrout (IF_ID_instrout),
        .IF_ID_npcout   (IF_ID_npcout),
        .IF_ID_valid    (IF_ID_valid)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag,
                        input logic r, input logic pcsrc, input logic [31:0] tgt,
                        input logic stl, input logic fl,
                        input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                        input logic [31:0] e_pc, input logic [31:0] e_instr,
                        input logic [31:0] e_npc, input logic e_valid);
        exp_t e;
        exp_t got;
        rst          = r;
        EX_MEM_pcsrc = pcsrc;
        EX_MEM_npc   = tgt;
        stall        = stl;
        flush        = fl;
        imem_we      = we;
        imem_waddr   = wa;
        imem_wdata   = wd;
        e.tag = tag; e.pc = e_pc; e.instr = e_instr; e.npc = e_npc; e.valid = e_valid;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        assert (pc_out === got.pc) else begin
            errors++;
            $error("FAIL %s pc_out obs=%h exp=%h", got.tag, pc_out, got.pc);
        end
        checks++;
        assert (IF_ID_instrout === got.instr) else begin
            errors++;
            $error("FAIL %s instr obs=%h exp=%h", got.tag, IF_ID_instrout, got.instr);
        end
        checks++;
        assert (IF_ID_npcout === got.npc) else begin
            errors++;
            $error("FAIL %s npc obs=%h exp=%h", got.tag, IF_ID_npcout, got.npc);
        end
        checks++;
        assert (IF_ID_valid === got.valid) else begin
            errors++;
            $error("FAIL %s valid obs=%b exp=%b", got.tag, IF_ID_valid, got.valid);
        end
    endtask

    task automatic run(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic [31:0] e_npc, input logic e_valid);
        step(tag, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, '0, 32'd0, e_pc, e_instr, e_npc, e_valid);
    endtask

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h0000_000A;
            1:       return 32'h0000_000B;
            2:       return 32'h0000_000C;
            3:       return 32'h0000_000D;
            5:       return 32'h0000_0055;
            64:      return 32'h0000_40C0;
            127:     return 32'h0000_7F7F;
            default: return 32'hF000_0000 | i;
        endcase
    endfunction

    initial begin
        // Load the whole memory while held in reset; outputs stay zero throughout.
        for (int i = 0; i < 128; i++) begin
            step("reset_load", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, AW'(i), init_word(i),
                 32'd0, 32'd0, 32'd0, 1'b0);
        end

        // Sequential fetch
        run("seq1", 32'd1, 32'hA, 32'd1, 1'b1);
        run("seq2", 32'd2, 32'hB, 32'd2, 1'b1);

        // Stall two cycles at PC=2
        step("stall1", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, '0, 32'd0, 32'd2, 32'hB, 32'd2, 1'b1);
        step("stall2", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, '0, 32'd0, 32'd2, 32'hB, 32'd2, 1'b1);
        run("resume1", 32'd3, 32'hC, 32'd3, 1'b1);
        run("resume2", 32'd4, 32'hD, 32'd4, 1'b1);

        // Redirect to 0x40
        step("redir", 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, '0, 32'd0, 32'h40, 32'd0, 32'd0, 1'b0);
        run("redir_fetch", 32'h41, 32'h40C0, 32'h41, 1'b1);

        // Redirect wins over stall for the PC
        step("redir_stall", 1'b0, 1'b1, 32'd5, 1'b1, 1'b0, 1'b0, '0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
        run("redir_stall_fetch", 32'd6, 32'h55, 32'd6, 1'b1);

        // Flush alone, then flush with stall
        step("flush", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, '0, 32'd0, 32'd7, 32'd0, 32'd0, 1'b0);
        step("flush_stall", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, '0, 32'd0, 32'd7, 32'd0, 32'd0, 1'b0);
        run("after_flush", 32'd8, 32'hF000_0007, 32'd8, 1'b1);

        // PC wrap-around at 0xFFFFFFFF
        step("wrap_redir", 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, '0, 32'd0,
             32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
        run("wrap_fetch", 32'd0, 32'h7F7F, 32'd0, 1'b1);

        // Put 0x11 in mem[3] while fetching index 0, then walk up to PC=3
        step("load3", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 7'd3, 32'h11, 32'd1, 32'hA, 32'd1, 1'b1);
        run("walk2", 32'd2, 32'hB, 32'd2, 1'b1);
        run("walk3", 32'd3, 32'hC, 32'd3, 1'b1);
        // Write 0x22 to index 3 while fetching it: old word is captured
        step("collide", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 7'd3, 32'h22, 32'd4, 32'h11, 32'd4, 1'b1);
        step("back_to3", 1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0, '0, 32'd0, 32'd3, 32'd0, 32'd0, 1'b0);
        run("new_word", 32'd4, 32'h22, 32'd4, 1'b1);

        // Reset during stall and redirect; memory survives, mem[0] fetched next
        step("rst_mid", 1'b1, 1'b1, 32'd9, 1'b1, 1'b0, 1'b0, '0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        run("post_rst", 32'd1, 32'hA, 32'd1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
